serializer_word_scheduler: RTL
==============================

// Module: serializer_word_scheduler
// PURPOSE
//  Word-level scheduler that feeds the PAR_IN bus of the 16:1 tree serializer.
//  - Shares the serial link between NUM_REQ requesters. Arbitration is round-robin.
//  - Runs a link-training preamble whenever the link is enabled.
//  - Holds each selected word stable for one full serialization period of
//    WORD_CYCLES clocks, then loads the next word on an exact word boundary.
//  - Sits directly upstream of the serializer, in the serializer's CLK domain.
// PARAMETERS
//  W            16        word width; equals serializer INPUTS_NUM
//  NUM_REQ      4         number of requesters (>=1)
//  WORD_CYCLES  16        CLK cycles per serialized word (>=2)
//  TRAIN_WORDS  4         training words sent after each enable (>=1)
//  TRAIN_WORD   16'hF00F  training pattern
//  IDLE_WORD    16'h0000  filler when disabled or no requester is valid
// PORTS
//  CLK        in   1            serializer word-side clock
//  RESET      in   1            asynchronous, active-high reset
//  en         in   1            link enable; sampled only at word boundaries
//  req_valid  in   NUM_REQ      per-requester word valid; data held until ready
//  req_data   in   NUM_REQ*W    word i at [i*W +: W]
//  req_ready  out  NUM_REQ      accept strobe; transfer when valid & ready
//  par_out    out  W            word to serializer PAR_IN (registered)
//  par_load   out  1            1-cycle pulse in the first cycle of a new par_out
//  cur_src    out  clog2(NUM_REQ)  requester index of the current par_out
//  src_valid  out  1            par_out holds requester data (not train/idle)
//  training   out  1            high while state==TRAIN
// BEHAVIOUR
//  Reset values (async):
//  - par_out=IDLE_WORD; par_load, src_valid and training are 0; cur_src=0.
//  - Internal: wc=0, rr_ptr=0, tcnt=0, state=OFF.
//  - req_ready is 0 while RESET is high.
//  Word counter:
//  - wc free-runs 0..WORD_CYCLES-1 and wraps, in every state.
//  - The boundary cycle B is the cycle where wc==WORD_CYCLES-1.
//  - All decisions are made in B and registered at the edge that ends B.
//  - The new par_out is visible, with par_load=1, in the cycle where wc==0.
//  - par_out is otherwise held constant for exactly WORD_CYCLES cycles.
//  FSM (transitions only in B):
//  - OFF, en=0: load IDLE_WORD.
//  - OFF, en=1: go to TRAIN, load TRAIN_WORD, tcnt<=1.
//  - TRAIN, en=0: go to OFF, load IDLE_WORD.
//  - TRAIN, en=1, tcnt<TRAIN_WORDS: load TRAIN_WORD, tcnt++.
//  - TRAIN, en=1, tcnt==TRAIN_WORDS: go to RUN and arbitrate in this same B.
//    Exactly TRAIN_WORDS training words are sent.
//  - RUN, en=0: go to OFF, load IDLE_WORD, no grant.
//  - RUN, en=1: arbitrate.
//  Arbitration (RUN or TRAIN->RUN, in B):
//  - Grant the first i with req_valid[i], searching from rr_ptr upward with wrap.
//  - On a grant to i:
//    - req_ready[i]=1 in B only. It is combinational from state, wc, rr_ptr and
//      req_valid, and is one-hot.
//    - par_out<=req_data[i]; cur_src<=i; src_valid<=1; rr_ptr<=(i+1)%NUM_REQ.
//  - If no requester is valid: load IDLE_WORD, src_valid<=0, rr_ptr unchanged.
//  - req_ready is 0 in every non-B cycle and in OFF/TRAIN.
//  Latency and handshake:
//  - A word accepted in B appears on par_out 1 cycle later.
//  - A valid that first rises in B is accepted in that B.
//  - A valid dropped before B is not granted; dropping valid without ready is
//    permitted here.
//  Mid-operation events:
//  - en changes mid-word: the current word completes; the change is seen only at B.
//  - Re-enabling from OFF always retrains.
//  - RESET mid-word: all state clears immediately and the partial word is abandoned.
//    A requester holding valid keeps its word and is served after retraining.
// TESTING
//  T1 Reset release, en=1, no requests:
//     -> par_load every 16 cycles; first 4 loads are F00F with training=1;
//        5th load is 0000 with training=0, src_valid=0.
//  T2 In RUN, req_valid=4'b0100, req_data[2]=16'h1234:
//     -> req_ready=4'b0100 for one cycle at wc==15;
//        next cycle par_out=1234, cur_src=2, src_valid=1;
//        held 16 cycles.
//  T3 All 4 valid continuously, data 16'h1000+i, rr_ptr=0:
//     -> successive words 1000,1001,1002,1003,1000;
//        ready one-hot each B.
//  T4 en 1->0 at wc==5 in RUN:
//     -> current word held until wc==15; next load 0000; no ready.
//     Then en=1:
//     -> 4 F00F words before any grant.
//  T5 RESET pulse at wc==7 during requester word:
//     -> par_out=0000, wc=0, req_ready=0 immediately;
//        after release with en=1, retrain then grant the held requester.
//  T6 req_valid[1] rises exactly at wc==15 -> accepted in that B;
//     req_valid[3] high for wc 4..10 only -> never readied.

Source files
------------

// File: rtl/serializer_word_scheduler.sv
// Word scheduler feeding the 16:1 tree serializer: a training preamble after each
// enable, then round-robin sharing of the link, one word per WORD_CYCLES clocks.
module serializer_word_scheduler #(
    parameter int           W           = 16,
    parameter int           NUM_REQ     = 4,
    parameter int           WORD_CYCLES = 16,
    parameter int           TRAIN_WORDS = 4,
    parameter logic [W-1:0] TRAIN_WORD  = 16'hF00F,
    parameter logic [W-1:0] IDLE_WORD   = 16'h0000,
    localparam int          SW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [W-1:0]         par_out,
    output logic                 par_load,
    output logic [SW-1:0]        cur_src,
    output logic                 src_valid,
    output logic                 training
);

    localparam int WCW = $clog2(WORD_CYCLES);
    localparam int TCW = $clog2(TRAIN_WORDS + 1);

    typedef enum logic [1:0] {OFF, TRAIN, RUN} state_t;

    state_t         state;
    logic [WCW-1:0] wc;
    logic [TCW-1:0] tcnt;
    logic [SW-1:0]  rr_ptr;

    logic           boundary;
    logic           arb_en;
    logic           gnt_found;
    logic [SW-1:0]  gnt_idx;
    logic [W-1:0]   gnt_data;

    assign boundary = (wc == WCW'(WORD_CYCLES - 1));
    assign arb_en   = boundary && en &&
                      ((state == RUN) || (state == TRAIN && tcnt == TCW'(TRAIN_WORDS)));

    // Round-robin search starting at rr_ptr, wrapping past the top requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_data  = IDLE_WORD;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = SW'((int'(rr_ptr) + k) % NUM_REQ);
                gnt_data  = req_data[((int'(rr_ptr) + k) % NUM_REQ) * W +: W];
            end
        end
    end

    assign req_ready = (arb_en && gnt_found && !RESET) ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Every decision is taken in the boundary cycle so par_out changes only on word edges.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= OFF;
            wc        <= '0;
            tcnt      <= '0;
            rr_ptr    <= '0;
            par_out   <= IDLE_WORD;
            par_load  <= 1'b0;
            cur_src   <= '0;
            src_valid <= 1'b0;
            training  <= 1'b0;
        end else begin
            wc       <= boundary ? '0 : wc + WCW'(1);
            par_load <= boundary;
            if (boundary) begin
                if (!en) begin
                    state     <= OFF;
                    training  <= 1'b0;
                    par_out   <= IDLE_WORD;
                    src_valid <= 1'b0;
                    tcnt      <= '0;
                end else if (state == OFF) begin
                    state     <= TRAIN;
                    training  <= 1'b1;
                    par_out   <= TRAIN_WORD;
                    src_valid <= 1'b0;
                    tcnt      <= TCW'(1);
                end else if (state == TRAIN && tcnt < TCW'(TRAIN_WORDS)) begin
                    par_out <= TRAIN_WORD;
                    tcnt    <= tcnt + TCW'(1);
                end else begin
                    state    <= RUN;
                    training <= 1'b0;
                    if (gnt_found) begin
                        par_out   <= gnt_data;
                        cur_src   <= gnt_idx;
                        src_valid <= 1'b1;
                        rr_ptr    <= (gnt_idx == SW'(NUM_REQ - 1)) ? '0 : gnt_idx + SW'(1);
                    end else begin
                        par_out   <= IDLE_WORD;
                        src_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
